// File: rtl/travel_plan_seq.sv
`default_nettype none
// ============================================================================
// Module      : travel_plan_seq
// Description : Line-following travel plan sequencer. Captures a 16-bit plan
//               of eight 2-bit maneuvers (LSB pair first), runs the follower
//               until a line gap is qualified, issues the next maneuver, then
//               waits for the line to be reacquired before resuming. A stop
//               code (00) at a gap ends the plan. Bump obstruction freezes
//               the sequencer and drops the motor enable.
//
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               cmd_rdy, cmd      - plan handshake and plan word from UART
//               clr_cmd_rdy       - one-cycle capture acknowledge
//               line_present      - IR line sensed (synchronous)
//               obstruct          - bump switch pressed (debounced)
//               go, in_transit    - motor enable, plan active
//               mnv, mnv_vld      - current maneuver and update strobe
//               buzz, buzz_n      - complementary piezo drive
//
// Options     : TRAVEL_BUZZ_EN    - when defined, a tone of half-period
//                                   BUZZ_DIV cycles sounds while obstructed
//                                   in transit; otherwise buzz/buzz_n are 0.
//
// Revision    : 1.0 - initial release
// ============================================================================
module travel_plan_seq #(
   parameter int GAP_CYC  = 4096,
   parameter int LINE_CYC = 256,
   parameter int BUZZ_DIV = 12500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_rdy,
   input  logic [15:0] cmd,
   output logic        clr_cmd_rdy,
   input  logic        line_present,
   input  logic        obstruct,
   output logic        go,
   output logic        in_transit,
   output logic [1:0]  mnv,
   output logic        mnv_vld,
   output logic        buzz,
   output logic        buzz_n
);

   localparam int C_CNT_MAX = (GAP_CYC > LINE_CYC) ? GAP_CYC : LINE_CYC;
   localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);
   localparam logic [C_CNT_W-1:0] C_GAP_CNT  = C_CNT_W'(GAP_CYC);
   localparam logic [C_CNT_W-1:0] C_LINE_CNT = C_CNT_W'(LINE_CYC);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FOLLOW   = 2'd1,
      GAP_WAIT = 2'd2,
      REACQ    = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [15:0]          plan_q, plan_d;
   logic [C_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic [C_CNT_W-1:0]   line_cnt_q, line_cnt_d;
   logic [1:0]           mnv_q, mnv_d;
   logic                 mnv_vld_q, mnv_vld_d;
   logic                 clr_q, clr_d;
   logic                 hold;

   // Obstruction only matters once a plan is running; in IDLE it is ignored.
   assign hold = obstruct & (state_q != IDLE);

   always_comb begin
      state_d    = state_q;
      plan_d     = plan_q;
      gap_cnt_d  = gap_cnt_q;
      line_cnt_d = line_cnt_q;
      mnv_d      = mnv_q;
      mnv_vld_d  = 1'b0;
      clr_d      = 1'b0;
      // While held, everything (including a pending gap qualification)
      // stays put and takes effect after release.
      if (!hold) begin
         case (state_q)
            IDLE: begin
               if (cmd_rdy) begin
                  plan_d     = cmd;
                  clr_d      = 1'b1;
                  gap_cnt_d  = '0;
                  line_cnt_d = '0;
                  state_d    = FOLLOW;
               end
            end
            FOLLOW: begin
               // Counter stops at GAP_CYC because reaching it exits the
               // state; it therefore saturates rather than wrapping.
               if (gap_cnt_q == C_GAP_CNT) begin
                  state_d = GAP_WAIT;
               end else if (line_present) begin
                  gap_cnt_d = '0;
               end else begin
                  gap_cnt_d = gap_cnt_q + 1'b1;
               end
            end
            GAP_WAIT: begin
               if (plan_q[1:0] == 2'b00) begin
                  plan_d     = '0;
                  mnv_d      = 2'b00;
                  gap_cnt_d  = '0;
                  line_cnt_d = '0;
                  state_d    = IDLE;
               end else begin
                  mnv_d      = plan_q[1:0];
                  mnv_vld_d  = 1'b1;
                  plan_d     = {2'b00, plan_q[15:2]};
                  line_cnt_d = '0;
                  state_d    = REACQ;
               end
            end
            REACQ: begin
               if (line_cnt_q == C_LINE_CNT) begin
                  gap_cnt_d  = '0;
                  line_cnt_d = '0;
                  state_d    = FOLLOW;
               end else if (line_present) begin
                  line_cnt_d = line_cnt_q + 1'b1;
               end else begin
                  line_cnt_d = '0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         plan_q     <= '0;
         gap_cnt_q  <= '0;
         line_cnt_q <= '0;
         mnv_q      <= 2'b00;
         mnv_vld_q  <= 1'b0;
         clr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         plan_q     <= plan_d;
         gap_cnt_q  <= gap_cnt_d;
         line_cnt_q <= line_cnt_d;
         mnv_q      <= mnv_d;
         mnv_vld_q  <= mnv_vld_d;
         clr_q      <= clr_d;
      end
   end

   assign in_transit  = (state_q != IDLE);
   assign go          = in_transit & ~obstruct;
   assign mnv         = mnv_q;
   assign mnv_vld     = mnv_vld_q;
   assign clr_cmd_rdy = clr_q;

`ifdef TRAVEL_BUZZ_EN
   localparam int C_DIV_W = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;
   localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(BUZZ_DIV - 1);

   logic [C_DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic               buzz_q, buzz_d;

   // Divider and tone phase restart from zero on every new obstruction.
   always_comb begin
      div_cnt_d = '0;
      buzz_d    = 1'b0;
      if (hold) begin
         if (div_cnt_q == C_DIV_LAST) begin
            div_cnt_d = '0;
            buzz_d    = ~buzz_q;
         end else begin
            div_cnt_d = div_cnt_q + 1'b1;
            buzz_d    = buzz_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_q <= '0;
         buzz_q    <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         buzz_q    <= buzz_d;
      end
   end

   // Gated by hold so both outputs drop the same cycle obstruct is released.
   assign buzz   = hold & buzz_q;
   assign buzz_n = hold & ~buzz_q;
`else
   assign buzz   = 1'b0;
   assign buzz_n = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_travel_plan_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_travel_plan_seq
// Description : Directed self-checking bench for travel_plan_seq with
//               GAP_CYC=8, LINE_CYC=4, BUZZ_DIV=3. Inputs change 1 time unit
//               after the rising edge and outputs are sampled there.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_travel_plan_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_rdy;
   logic [15:0] cmd;
   logic        clr_cmd_rdy;
   logic        line_present;
   logic        obstruct;
   logic        go;
   logic        in_transit;
   logic [1:0]  mnv;
   logic        mnv_vld;
   logic        buzz;
   logic        buzz_n;

   int n_tests = 0;
   int n_fail  = 0;

   travel_plan_seq #(
      .GAP_CYC  (8),
      .LINE_CYC (4),
      .BUZZ_DIV (3)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_rdy      (cmd_rdy),
      .cmd          (cmd),
      .clr_cmd_rdy  (clr_cmd_rdy),
      .line_present (line_present),
      .obstruct     (obstruct),
      .go           (go),
      .in_transit   (in_transit),
      .mnv          (mnv),
      .mnv_vld      (mnv_vld),
      .buzz         (buzz),
      .buzz_n       (buzz_n)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a plan in IDLE and report the acknowledge over two cycles.
   task automatic start_plan(input logic [15:0] plan, output logic clr0, output logic clr1);
      cmd     = plan;
      cmd_rdy = 1'b1;
      tick();
      clr0    = clr_cmd_rdy;
      cmd_rdy = 1'b0;
      tick();
      clr1    = clr_cmd_rdy;
   endtask

   // Drop the line for n_absent cycles, then restore it long enough for any
   // gap handling and reacquire to complete; counts mnv_vld pulses seen.
   task automatic run_gap(input int n_absent, output int n_vld, output logic [1:0] vld_mnv);
      n_vld   = 0;
      vld_mnv = 2'b00;
      line_present = 1'b0;
      for (int i = 0; i < n_absent; i++) begin
         tick();
         if (mnv_vld) begin n_vld++; vld_mnv = mnv; end
      end
      line_present = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (mnv_vld) begin n_vld++; vld_mnv = mnv; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      n_tests++;
      if ({go, in_transit, mnv, mnv_vld, clr_cmd_rdy, buzz, buzz_n} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b required 00000000",
                  {go, in_transit, mnv, mnv_vld, clr_cmd_rdy, buzz, buzz_n});
      end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_idle_obstruct();
      obstruct = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      n_tests++;
      if ({go, in_transit, buzz, buzz_n, mnv} !== 6'b000000) begin
         n_fail++;
         $display("FAIL idle_obstruct: got go/it/buzz/buzz_n/mnv=%b required 000000",
                  {go, in_transit, buzz, buzz_n, mnv});
      end
      obstruct = 1'b0;
      tick();
   endtask

   task automatic test_plan_2d();
      logic c0, c1;
      int nv;
      logic [1:0] m;
      logic [1:0] exp_m [3] = '{2'b01, 2'b11, 2'b10};
      start_plan(16'h002D, c0, c1);
      n_tests++;
      if ({c0, c1, go, in_transit} !== 4'b1011) begin
         n_fail++;
         $display("FAIL capture_ack: got clr0/clr1/go/it=%b required 1011", {c0, c1, go, in_transit});
      end
      for (int g = 0; g < 3; g++) begin
         run_gap(8, nv, m);
         n_tests++;
         if (nv !== 1 || m !== exp_m[g] || mnv !== exp_m[g] || go !== 1'b1) begin
            n_fail++;
            $display("FAIL plan2d_gap%0d: got pulses=%0d mnv=%b held=%b go=%b required pulses=1 mnv=%b go=1",
                     g, nv, m, mnv, go, exp_m[g]);
         end
      end
      run_gap(8, nv, m);
      n_tests++;
      if (nv !== 0 || {go, in_transit, mnv} !== 4'b0000) begin
         n_fail++;
         $display("FAIL plan2d_stop: got pulses=%0d go/it/mnv=%b required pulses=0 0000",
                  nv, {go, in_transit, mnv});
      end
   endtask

   task automatic test_plan_5555();
      logic c0, c1;
      int nv;
      logic [1:0] m;
      start_plan(16'h5555, c0, c1);
      for (int g = 0; g < 8; g++) begin
         run_gap(8, nv, m);
         n_tests++;
         if (nv !== 1 || m !== 2'b01 || in_transit !== 1'b1) begin
            n_fail++;
            $display("FAIL plan5555_gap%0d: got pulses=%0d mnv=%b it=%b required 1 01 1", g, nv, m, in_transit);
         end
      end
      run_gap(8, nv, m);
      n_tests++;
      if (nv !== 0 || {go, in_transit} !== 2'b00) begin
         n_fail++;
         $display("FAIL plan5555_stop9: got pulses=%0d go/it=%b required 0 00", nv, {go, in_transit});
      end
   endtask

   // Leaves a running plan (0x5555 with two maneuvers consumed) in FOLLOW.
   task automatic test_dropout_and_ignore();
      logic c0, c1;
      int nv;
      int nclr;
      logic [1:0] m;
      start_plan(16'h5555, c0, c1);
      run_gap(7, nv, m);
      n_tests++;
      if (nv !== 0 || in_transit !== 1'b1) begin
         n_fail++;
         $display("FAIL dropout7: got pulses=%0d it=%b required 0 1", nv, in_transit);
      end
      run_gap(8, nv, m);
      n_tests++;
      if (nv !== 1 || m !== 2'b01) begin
         n_fail++;
         $display("FAIL dropout8: got pulses=%0d mnv=%b required 1 01", nv, m);
      end
      nclr    = 0;
      cmd     = 16'hFFFF;
      cmd_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (clr_cmd_rdy) nclr++;
      end
      cmd_rdy = 1'b0;
      n_tests++;
      if (nclr !== 0) begin
         n_fail++;
         $display("FAIL cmd_rdy_ignored: got %0d acks required 0", nclr);
      end
      run_gap(8, nv, m);
      n_tests++;
      if (nv !== 1 || m !== 2'b01) begin
         n_fail++;
         $display("FAIL plan_unchanged: got pulses=%0d mnv=%b required 1 01", nv, m);
      end
   endtask

   task automatic test_obstruct();
      int bad_buzz = 0;
      int early    = 0;
      logic exp_b, exp_bn;
      line_present = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      obstruct = 1'b1;
      #1;
      n_tests++;
      if ({go, in_transit} !== 2'b01) begin
         n_fail++;
         $display("FAIL obstruct_go: got go/it=%b required 01", {go, in_transit});
      end
      for (int k = 1; k <= 10; k++) begin
         tick();
`ifdef TRAVEL_BUZZ_EN
         exp_b  = ((k / 3) % 2) == 1;
         exp_bn = ~exp_b;
`else
         exp_b  = 1'b0;
         exp_bn = 1'b0;
`endif
         if (buzz !== exp_b || buzz_n !== exp_bn || go !== 1'b0 || mnv_vld !== 1'b0) bad_buzz++;
      end
      n_tests++;
      if (bad_buzz !== 0) begin
         n_fail++;
         $display("FAIL obstruct_hold_buzz: got %0d bad cycles required 0", bad_buzz);
      end
      obstruct = 1'b0;
      #1;
      n_tests++;
      if ({go, buzz, buzz_n} !== 3'b100) begin
         n_fail++;
         $display("FAIL release_go: got go/buzz/buzz_n=%b required 100", {go, buzz, buzz_n});
      end
      // Gap counter held at 5: three more absent cycles qualify, then
      // GAP_WAIT, then the maneuver strobe.
      for (int i = 0; i < 4; i++) begin
         tick();
         if (mnv_vld) early++;
      end
      tick();
      n_tests++;
      if (early !== 0 || mnv_vld !== 1'b1 || mnv !== 2'b01) begin
         n_fail++;
         $display("FAIL resume_count: got early=%0d vld=%b mnv=%b required 0 1 01", early, mnv_vld, mnv);
      end
      line_present = 1'b1;
      for (int i = 0; i < 10; i++) tick();
   endtask

   task automatic test_override();
      int bad = 0;
      line_present = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      obstruct = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (mnv_vld !== 1'b0 || in_transit !== 1'b1 || go !== 1'b0) bad++;
      end
      obstruct = 1'b0;
      tick();
      if (mnv_vld !== 1'b0) bad++;
      tick();
      n_tests++;
      if (bad !== 0 || mnv_vld !== 1'b1 || mnv !== 2'b01) begin
         n_fail++;
         $display("FAIL gap_override: got bad=%0d vld=%b mnv=%b required 0 1 01", bad, mnv_vld, mnv);
      end
      line_present = 1'b1;
      for (int i = 0; i < 10; i++) tick();
   endtask

   task automatic test_reset_in_reacq();
      int bad = 0;
      line_present = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      line_present = 1'b1;
      tick();
      tick();
      n_tests++;
      if (mnv_vld !== 1'b1 || go !== 1'b1) begin
         n_fail++;
         $display("FAIL reacq_entry: got vld=%b go=%b required 1 1", mnv_vld, go);
      end
      rst = 1'b1;
      #1;
      n_tests++;
      if ({go, in_transit, mnv, mnv_vld, clr_cmd_rdy, buzz, buzz_n} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_reacq: got %b required 00000000",
                  {go, in_transit, mnv, mnv_vld, clr_cmd_rdy, buzz, buzz_n});
      end
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (clr_cmd_rdy !== 1'b0 || in_transit !== 1'b0) bad++;
      end
      n_tests++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL reset_discard: got %0d bad cycles required 0", bad);
      end
   endtask

   initial begin
      rst          = 1'b1;
      cmd_rdy      = 1'b0;
      cmd          = 16'h0000;
      line_present = 1'b1;
      obstruct     = 1'b0;
      test_reset();
      test_idle_obstruct();
      test_plan_2d();
      test_plan_5555();
      test_dropout_and_ignore();
      test_obstruct();
      test_override();
      test_reset_in_reacq();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/travel_plan_seq.md
TRAVEL_PLAN_SEQ -- requirements
Module: travel_plan_seq

Interface
REQ-001 SHALL have parameter GAP_CYC, default 4096: consecutive line-absent cycles that qualify a gap.
REQ-002 SHALL have parameter LINE_CYC, default 256: consecutive line-present cycles that qualify line reacquire.
REQ-003 SHALL have parameter BUZZ_DIV, default 12500: half-period of the buzzer tone, in clk cycles.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port cmd_rdy, input, 1 bit: UART wrapper holds a 16-bit travel plan.
REQ-007 SHALL have port cmd, input, 16 bits: travel plan of 2-bit maneuvers, LSB pair first; 00 stop, 01 veer right, 10 veer left, 11 turn around.
REQ-008 SHALL have port clr_cmd_rdy, output, 1 bit: one-cycle pulse acknowledging cmd capture.
REQ-009 SHALL have port line_present, input, 1 bit: IR line sensed (already synchronized).
REQ-010 SHALL have port obstruct, input, 1 bit: either bump switch pressed (debounced, active-high).
REQ-011 SHALL have port go, output, 1 bit: motor enable to the PID/motor stage.
REQ-012 SHALL have port in_transit, output, 1 bit: plan active.
REQ-013 SHALL have port mnv, output, 2 bits: current maneuver code, held until next gap.
REQ-014 SHALL have port mnv_vld, output, 1 bit: one-cycle pulse when mnv is updated.
REQ-015 SHALL have ports buzz and buzz_n, output, 1 bit each: piezo drive, complementary.

Function
REQ-016 SHALL implement states IDLE, FOLLOW, GAP_WAIT, REACQ.
- IDLE: go=0, in_transit=0; on cmd_rdy=1, capture cmd into plan register, pulse clr_cmd_rdy same cycle, go to FOLLOW.
- FOLLOW: go=1; count consecutive line_present=0 cycles; counter clears on any line_present=1; at count == GAP_CYC go to GAP_WAIT.
- GAP_WAIT (one cycle): if plan[1:0]==00 go to IDLE with go=0, in_transit=0 on the next cycle; else mnv<=plan[1:0], pulse mnv_vld, plan<=plan>>2 (zero-fill), go to REACQ.
- REACQ: go=1; count consecutive line_present=1 cycles; at LINE_CYC return to FOLLOW with both counters cleared.
REQ-017 SHALL latch cmd_rdy only in IDLE; cmd_rdy outside IDLE is ignored and not acknowledged.
REQ-018 After 8 non-stop maneuvers the plan SHALL be all zeros, so the next gap stops the runner.
REQ-019 While obstruct=1 and in_transit=1: go=0, state frozen, both counters held; resume in the same state the cycle after obstruct falls.
REQ-020 obstruct SHALL override a simultaneous gap qualification; the qualification takes effect after release.
REQ-021 obstruct in IDLE SHALL have no effect; buzz stays 0.
REQ-022 Counters SHALL saturate and never wrap; their width is ceil(log2(max(GAP_CYC,LINE_CYC)+1)).
REQ-023 mnv SHALL read 00 in IDLE and hold its value through FOLLOW/REACQ.

Reset
REQ-024 On rst=1, asynchronously: state IDLE, plan=0, counters=0, mnv=00, mnv_vld=0, clr_cmd_rdy=0, go=0, in_transit=0, buzz=0, buzz_n=0.
REQ-025 Reset mid-plan SHALL discard the plan; no acknowledge is re-issued.

Configuration
REQ-026 Macro TRAVEL_BUZZ_EN defined: while obstructed in transit, buzz toggles every BUZZ_DIV cycles with buzz_n = ~buzz; otherwise both are 0.
REQ-027 Macro TRAVEL_BUZZ_EN undefined: buzz and buzz_n are constant 0 and no tone divider exists; all other behaviour is unchanged.

Verification (bench uses GAP_CYC=8, LINE_CYC=4, BUZZ_DIV=3)
REQ-028 cmd=16'h002D, cmd_rdy=1 -> clr_cmd_rdy pulse; three gaps give mnv 01, 11, 10, each with mnv_vld; the fourth gap gives go=0, in_transit=0.
REQ-029 cmd=16'h5555 -> 8 gaps give mnv=01 each; the 9th gap stops the runner.
REQ-030 Line dropout of 7 cycles in FOLLOW -> no mnv_vld; dropout of 8 cycles -> mnv_vld exactly once.
REQ-031 obstruct=1 for 10 cycles in FOLLOW -> go=0 and, with TRAVEL_BUZZ_EN, buzz toggles every 3 cycles; go=1 the cycle after release, and the gap counter resumes from its held value.
REQ-032 cmd_rdy pulsed during FOLLOW -> no clr_cmd_rdy and plan unchanged; rst asserted in REACQ -> all outputs 0 immediately.
